tamper_event_monitor: RTL

- Fabric-side consumer of the SmartFusion2 TAMPER macro status outputs.
- Synchronises the tamper status bus into the fabric clock domain and detects each TAMPER_CHANGE_STROBE pulse.
- After a settle window, snapshots the status into an event record, queues it in a small FIFO and keeps saturating attempt/fail counters.
- Raises a level interrupt for the MSS/firmware that runs the post-ISP device-restart flow.

---
 rtl/tamper_event_monitor.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/tamper_event_monitor.sv
// Fabric-side monitor for the SmartFusion2 TAMPER status outputs: synchronises the status bus, captures
// an event record per change strobe into a FWFT FIFO, keeps counters/sticky flags and drives IRQ.
// Optional build macro: TAMPER_MON_TIMESTAMP_EN appends a 16-bit edge timestamp to each record.
module tamper_event_monitor #(
  parameter int FIFO_DEPTH    = 8,
  parameter int CNT_W         = 8,
  parameter int SETTLE_CYCLES = 2,
`ifdef TAMPER_MON_TIMESTAMP_EN
  localparam int REC_W        = 27
`else
  localparam int REC_W        = 11
`endif
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             JTAG_ACTIVE,
  input  logic             LOCK_TAMPER_DETECT,
  input  logic             MESH_SHORT_ERROR,
  input  logic [3:0]       DETECT_CATEGORY,
  input  logic             DETECT_ATTEMPT,
  input  logic             DETECT_FAIL,
  input  logic             DIGEST_ERROR,
  input  logic             SC_ROM_DIGEST_ERROR,
  input  logic             TAMPER_CHANGE_STROBE,
  input  logic             RD_EN,
  output logic [REC_W-1:0] RD_DATA,
  output logic             EMPTY,
  output logic             FULL,
  output logic             OVERFLOW,
  output logic             DIGEST_STICKY,
  output logic [CNT_W-1:0] ATTEMPT_CNT,
  output logic [CNT_W-1:0] FAIL_CNT,
  output logic             IRQ,
  input  logic             IRQ_CLR
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         settle_q, settle_d;
  logic [11:0]        sync1_q, sync1_d;
  logic [11:0]        sync2_q, sync2_d;
  logic               strb_prev_q, strb_prev_d;
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [REC_W-1:0]   mem_q [FIFO_DEPTH];
  logic [REC_W-1:0]   mem_d [FIFO_DEPTH];
  logic               overflow_q, overflow_d;
  logic               digest_q, digest_d;
  logic [CNT_W-1:0]   attempt_q, attempt_d;
  logic [CNT_W-1:0]   fail_q, fail_d;
  logic               irq_q, irq_d;

  logic [10:0]        stat_async;
  logic [10:0]        stat_sync;
  logic [REC_W-1:0]   rec;
  logic               edge_det;
  logic               empty;
  logic               full;
  logic               rd_fire;
  logic               push;

  assign stat_async = {DETECT_CATEGORY, DETECT_ATTEMPT, DETECT_FAIL, DIGEST_ERROR,
                       SC_ROM_DIGEST_ERROR, MESH_SHORT_ERROR, LOCK_TAMPER_DETECT, JTAG_ACTIVE};
  assign stat_sync  = sync2_q[10:0];
  assign edge_det   = sync2_q[11] & ~strb_prev_q;

`ifdef TAMPER_MON_TIMESTAMP_EN
  logic [15:0] ts_q, ts_d;
  logic [15:0] ts_hold_q, ts_hold_d;

  // Timestamp is latched on the edge-detect cycle, not at capture, so it marks when the strobe arrived.
  always_comb begin
    ts_d      = ts_q + 16'd1;
    ts_hold_d = ts_hold_q;
    if (state_q == S_IDLE && edge_det) begin
      ts_hold_d = ts_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ts_q      <= '0;
      ts_hold_q <= '0;
    end else begin
      ts_q      <= ts_d;
      ts_hold_q <= ts_hold_d;
    end
  end

  assign rec = {stat_sync, ts_hold_q};
`else
  assign rec = stat_sync;
`endif

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_fire = RD_EN && !empty;
  assign push    = (state_q == S_CAPTURE);

  always_comb begin
    sync1_d     = {TAMPER_CHANGE_STROBE, stat_async};
    sync2_d     = sync1_q;
    strb_prev_d = sync2_q[11];
    state_d     = state_q;
    settle_d    = settle_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_d       = mem_q;
    overflow_d  = overflow_q;
    digest_d    = digest_q;
    attempt_d   = attempt_q;
    fail_d      = fail_q;

    case (state_q)
      S_IDLE: begin
        if (edge_det) begin
          state_d  = S_SETTLE;
          settle_d = 4'(SETTLE_CYCLES - 1);
        end
      end
      S_SETTLE: begin
        if (edge_det) overflow_d = 1'b1;
        if (settle_q == 4'd0) state_d = S_CAPTURE;
        else                  settle_d = settle_q - 4'd1;
      end
      S_CAPTURE: begin
        if (edge_det) overflow_d = 1'b1;
        state_d = S_IDLE;
        if (stat_sync[6] && attempt_q != {CNT_W{1'b1}}) attempt_d = attempt_q + 1'b1;
        if (stat_sync[5] && fail_q != {CNT_W{1'b1}})    fail_d    = fail_q + 1'b1;
        if (stat_sync[4] || stat_sync[3])               digest_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (rd_fire) rd_ptr_d = rd_ptr_q + (AW+1)'(1);

    // A simultaneous pop frees the head slot, so a push into a full FIFO still succeeds.
    if (push) begin
      if (!full || rd_fire) begin
        mem_d[wr_ptr_q[AW-1:0]] = rec;
        wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end else begin
        overflow_d = 1'b1;
      end
    end

    if (IRQ_CLR) begin
      overflow_d = 1'b0;
      digest_d   = 1'b0;
      attempt_d  = '0;
      fail_d     = '0;
    end

    irq_d = !empty || overflow_q || digest_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      settle_q    <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      strb_prev_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_q       <= '{default: '0};
      overflow_q  <= 1'b0;
      digest_q    <= 1'b0;
      attempt_q   <= '0;
      fail_q      <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      strb_prev_q <= strb_prev_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_q       <= mem_d;
      overflow_q  <= overflow_d;
      digest_q    <= digest_d;
      attempt_q   <= attempt_d;
      fail_q      <= fail_d;
      irq_q       <= irq_d;
    end
  end

  assign RD_DATA       = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign EMPTY         = empty;
  assign FULL          = full;
  assign OVERFLOW      = overflow_q;
  assign DIGEST_STICKY = digest_q;
  assign ATTEMPT_CNT   = attempt_q;
  assign FAIL_CNT      = fail_q;
  assign IRQ           = irq_q;

endmodule
